// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry instruction prefetch queue over a single-port memory shared with load/store
// Optional feature: define FETCH_STORE_SNOOP_EN to patch queued and in-flight instructions on matching stores.
module fetch_queue #(
   parameter int                DATA_W     = 17,
   parameter int                ADDR_W     = 10,
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dequeue_i,
   input  logic              restart_i,
   input  logic [ADDR_W-1:0] restart_addr_i,
   input  logic              load_store_valid_i,
   input  logic              store_en_i,
   input  logic [ADDR_W-1:0] load_store_addr_i,
   input  logic [DATA_W-1:0] store_data_i,
   output logic [DATA_W-1:0] load_data_o,
   output logic              load_data_valid_o,
   output logic [DATA_W-1:0] instruction_data_o,
   output logic [ADDR_W-1:0] instruction_addr_o,
   output logic              instruction_valid_o
);
   localparam int CW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [CW-1:0]     head;
   logic [CW-1:0]     tail;
   logic [CW:0]       count;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] fill_addr;
   logic              inflight;
   logic              load_pending;
   logic [DATA_W-1:0] load_hold;

   logic              ls_load;
   logic              ls_store;
   logic              pop;
   logic              fill;
   logic              issue;
   logic [CW+1:0]     occupancy;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] fill_data;

   always_comb begin
      ls_load   = load_store_valid_i & ~store_en_i;
      ls_store  = load_store_valid_i & store_en_i;
      pop       = dequeue_i & instruction_valid_o & ~restart_i;
      fill      = inflight & ~restart_i;
      // Entries already owned (queued + in flight) after this cycle's pop.
      occupancy = {1'b0, count} + {{(CW+1){1'b0}}, inflight} - {{(CW+1){1'b0}}, pop};
      issue     = ~load_store_valid_i & ~restart_i & (occupancy < (CW+2)'(DEPTH));
      rd_addr   = load_store_valid_i ? load_store_addr_i : pc;
      fill_data = rd_data;
`ifdef FETCH_STORE_SNOOP_EN
      if (ls_store && (load_store_addr_i == fill_addr))
         fill_data = store_data_i;
`endif
   end

   // Single shared port: a store writes, anything else reads into rd_data.
   always_ff @(posedge clk) begin
      if (ls_store)
         mem[load_store_addr_i] <= store_data_i;
      else
         rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         pc           <= RESET_ADDR;
         fill_addr    <= '0;
         inflight     <= 1'b0;
         load_pending <= 1'b0;
         load_hold    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_data[i] <= '0;
            q_addr[i] <= '0;
         end
      end else begin
         load_pending <= ls_load;
         if (load_pending)
            load_hold <= rd_data;
`ifdef FETCH_STORE_SNOOP_EN
         // Placed before the fill so a fresh fill into a stale matching slot wins.
         if (ls_store) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (q_addr[i] == load_store_addr_i)
                  q_data[i] <= store_data_i;
            end
         end
`endif
         if (restart_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            pc       <= restart_addr_i;
         end else begin
            if (fill) begin
               q_data[tail] <= fill_data;
               q_addr[tail] <= fill_addr;
               tail         <= tail + 1'b1;
            end
            if (pop)
               head <= head + 1'b1;
            count    <= count + {{CW{1'b0}}, fill} - {{CW{1'b0}}, pop};
            inflight <= issue;
            if (issue) begin
               fill_addr <= pc;
               pc        <= pc + 1'b1;
            end
         end
      end
   end

   assign instruction_valid_o = (count != '0);
   assign instruction_data_o  = q_data[head];
   assign instruction_addr_o  = q_addr[head];
   assign load_data_valid_o   = load_pending;
   assign load_data_o         = load_pending ? rd_data : load_hold;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue against a queue-based reference model
module tb_fetch_queue;
   localparam int DW    = 17;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int NW    = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dequeue_i = 1'b0;
   logic          restart_i = 1'b0;
   logic [AW-1:0] restart_addr_i = '0;
   logic          load_store_valid_i = 1'b0;
   logic          store_en_i = 1'b0;
   logic [AW-1:0] load_store_addr_i = '0;
   logic [DW-1:0] store_data_i = '0;
   logic [DW-1:0] load_data_o;
   logic          load_data_valid_o;
   logic [DW-1:0] instruction_data_o;
   logic [AW-1:0] instruction_addr_o;
   logic          instruction_valid_o;

   always #5 clk = ~clk;

   fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_ADDR(4'd0)) dut (
      .clk(clk), .rst(rst), .dequeue_i(dequeue_i), .restart_i(restart_i),
      .restart_addr_i(restart_addr_i), .load_store_valid_i(load_store_valid_i),
      .store_en_i(store_en_i), .load_store_addr_i(load_store_addr_i),
      .store_data_i(store_data_i), .load_data_o(load_data_o),
      .load_data_valid_o(load_data_valid_o), .instruction_data_o(instruction_data_o),
      .instruction_addr_o(instruction_addr_o), .instruction_valid_o(instruction_valid_o)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   ent_t          pop_sb[$];
   logic [DW-1:0] load_sb[$];
   logic [DW-1:0] mm [NW];
   logic          m_infl = 1'b0;
   ent_t          m_infl_e;
   int            m_pc = 0;
   logic          exp_valid = 1'b0;
   ent_t          exp_head;
   logic [DW-1:0] last_load = '0;
   int            errors = 0;
   int            checks = 0;
   int            wrap_exp[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: advances by one clock edge using the inputs of the current cycle.
   task automatic model_step();
      int occ;
      bit pop;
      if (rst) begin
         mq.delete();
         load_sb.delete();
         m_infl    = 1'b0;
         m_pc      = 0;
         exp_valid = 1'b0;
         return;
      end
      exp_valid = (mq.size() != 0);
      if (exp_valid) exp_head = mq[0];
      pop = dequeue_i && exp_valid && !restart_i;
      occ = mq.size() + int'(m_infl) - int'(pop);
      if (pop) begin
         pop_sb.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (load_store_valid_i && !store_en_i) load_sb.push_back(mm[load_store_addr_i]);
      if (restart_i) begin
         mq.delete();
         m_infl = 1'b0;
         m_pc   = int'(restart_addr_i);
      end else begin
         if (m_infl) begin
            mq.push_back(m_infl_e);
            m_infl = 1'b0;
         end
         if (!load_store_valid_i && occ < DEPTH) begin
            m_infl        = 1'b1;
            m_infl_e.addr = AW'(m_pc);
            m_infl_e.data = mm[m_pc];
            m_pc          = (m_pc + 1) % NW;
         end
      end
      if (load_store_valid_i && store_en_i) begin
         mm[load_store_addr_i] = store_data_i;
`ifdef FETCH_STORE_SNOOP_EN
         foreach (mq[i]) if (mq[i].addr == load_store_addr_i) mq[i].data = store_data_i;
`endif
      end
   endtask

   always @(posedge clk) begin
      #3;
      model_step();
   end

   // Monitor: compares the visible head every cycle and pops the scoreboards on DUT pops / load pulses.
   always @(negedge clk) begin
      ent_t e;
      chk("valid", 32'(instruction_valid_o), 32'(exp_valid));
      if (exp_valid && instruction_valid_o) begin
         chk("head_addr", 32'(instruction_addr_o), 32'(exp_head.addr));
         chk("head_data", 32'(instruction_data_o), 32'(exp_head.data));
      end
      if (!rst && instruction_valid_o && dequeue_i && !restart_i) begin
         if (pop_sb.size() == 0) begin
            chk("pop_unexpected", 32'(1), 32'(0));
         end else begin
            e = pop_sb.pop_front();
            chk("pop_addr", 32'(instruction_addr_o), 32'(e.addr));
            chk("pop_data", 32'(instruction_data_o), 32'(e.data));
         end
      end
      if (rst) last_load = '0;
      if (load_data_valid_o) begin
         if (load_sb.size() == 0) begin
            chk("load_unexpected", 32'(1), 32'(0));
         end else begin
            last_load = load_sb.pop_front();
            chk("load_data", 32'(load_data_o), 32'(last_load));
         end
      end else begin
         chk("load_hold", 32'(load_data_o), 32'(last_load));
      end
   end

   task automatic drive(input bit d, input bit rs, input int ra, input bit v, input bit s,
                        input int a, input int dat);
      @(posedge clk); #2;
      dequeue_i          = d;
      restart_i          = rs;
      restart_addr_i     = AW'(ra);
      load_store_valid_i = v;
      store_en_i         = s;
      load_store_addr_i  = AW'(a);
      store_data_i       = DW'(dat);
   endtask

   task automatic idle(input int n, input bit d);
      for (int i = 0; i < n; i++) drive(d, 1'b0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #2;
      rst = 1'b1;
      dequeue_i = 1'b0; restart_i = 1'b0; load_store_valid_i = 1'b0; store_en_i = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(instruction_valid_o), 32'(0));
      chk("rst_iaddr", 32'(instruction_addr_o), 32'(0));
      chk("rst_idata", 32'(instruction_data_o), 32'(0));
      chk("rst_lvalid", 32'(load_data_valid_o), 32'(0));
      chk("rst_ldata", 32'(load_data_o), 32'(0));
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic restart_then_check(input int ra, input int expd, input bit d);
      drive(d, 1'b1, ra, 1'b0, 1'b0, 0, 0);
      idle(1, 1'b0);
      @(negedge clk);
      chk("restart_flush", 32'(instruction_valid_o), 32'(0));
      idle(2, 1'b0);
      @(negedge clk);
      chk("restart_valid", 32'(instruction_valid_o), 32'(1));
      chk("restart_addr", 32'(instruction_addr_o), 32'(ra));
      chk("restart_data", 32'(instruction_data_o), 32'(expd));
   endtask

   initial begin
      int snoop_exp;
      wrap_exp[0] = 14; wrap_exp[1] = 15; wrap_exp[2] = 0; wrap_exp[3] = 1;
      repeat (2) @(negedge clk);
      chk("init_valid", 32'(instruction_valid_o), 32'(0));
      chk("init_ldata", 32'(load_data_o), 32'(0));
      chk("init_idata", 32'(instruction_data_o), 32'(0));

      // Preload mem[i] = i through the store port.
      for (int i = 0; i < NW; i++) begin
         drive(1'b0, 1'b0, 0, 1'b1, 1'b1, i, i);
         rst = 1'b0;
      end
      reset_pulse();

      // Reset then prefetch: queue fills with 0..3, then pop them.
      idle(8, 1'b0);
      @(negedge clk);
      chk("prefetch_addr", 32'(instruction_addr_o), 32'(0));
      chk("prefetch_data", 32'(instruction_data_o), 32'(0));
      idle(4, 1'b1);
      idle(1, 1'b0);

      // Restart mid-stream with dequeue asserted during the restart cycle.
      restart_then_check(0, 0, 1'b0);
      idle(4, 1'b0);
      restart_then_check(3, 3, 1'b1);
      idle(3, 1'b0);

      // Store then restart onto the modified word.
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 2, 'h10005);
      restart_then_check(2, 'h10005, 1'b0);
      idle(3, 1'b0);

      // Load contention while dequeuing continuously.
      idle(3, 1'b1);
      drive(1'b1, 1'b0, 0, 1'b1, 1'b0, 7, 0);
      idle(5, 1'b1);
      idle(1, 1'b0);

      // PC wrap.
      drive(1'b1, 1'b1, 14, 1'b0, 1'b0, 0, 0);
      idle(3, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("wrap_valid", 32'(instruction_valid_o), 32'(1));
         chk("wrap_addr", 32'(instruction_addr_o), 32'(wrap_exp[k]));
      end
      idle(1, 1'b0);

      // Store to a queued instruction (entries 4..7 queued).
      restart_then_check(4, 4, 1'b0);
      idle(3, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 'h1FFFF);
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
      idle(1, 1'b0);
      @(negedge clk);
`ifdef FETCH_STORE_SNOOP_EN
      snoop_exp = 'h1FFFF;
`else
      snoop_exp = 5;
`endif
      chk("snoop_addr", 32'(instruction_addr_o), 32'(5));
      chk("snoop_data", 32'(instruction_data_o), 32'(snoop_exp));

      // Randomized traffic, with one reset in the middle.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) reset_pulse();
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 5, int'($urandom_range(0, NW-1)),
               $urandom_range(0, 99) < 18, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, NW-1)), int'($urandom_range(0, (1 << DW) - 1)));
      end
      idle(6, 1'b0);
      @(negedge clk);
      chk("pop_sb_drained", 32'(pop_sb.size()), 32'(0));
      chk("load_sb_drained", 32'(load_sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch unit with a DEPTH-entry prefetch queue over a single-port unified memory shared with a load/store port. It replaces the fixed 17-bit/10-bit fetch unit and adds configurable widths and queue depth, explicit asynchronous reset and a reset PC, and optional store snooping of prefetched instructions. It sits between memory and decode: decode pops instructions with `dequeue_i`, and branch resolution redirects it with `restart_i`.

## Interface
- `DATA_W`, 17, instruction and data word width.
- `ADDR_W`, 10, word-address width; memory holds 2^ADDR_W words.
- `DEPTH`, 4, prefetch queue entries; power of two, at least 2.
- `RESET_ADDR`, 0, PC value after reset.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dequeue_i` in 1: pop the queue head; ignored when the queue is empty.
- `restart_i` in 1: flush the queue and redirect the PC.
- `restart_addr_i` in ADDR_W: new PC.
- `load_store_valid_i` in 1: memory access request.
- `store_en_i` in 1: 1 = store, 0 = load.
- `load_store_addr_i` in ADDR_W: access address.
- `store_data_i` in DATA_W: store data.
- `load_data_o` out DATA_W: load result.
- `load_data_valid_o` out 1: one-cycle pulse marking a load result.
- `instruction_data_o` out DATA_W: queue-head instruction.
- `instruction_addr_o` out ADDR_W: queue-head address.
- `instruction_valid_o` out 1: queue non-empty.

## Operation
- **Reset.** Queue empty, no read in flight, PC = RESET_ADDR, all outputs 0. Memory contents are not cleared.
- **Port priority.** One memory access per cycle: load/store first, then fetch.
  - A load or store request blocks fetch issue that cycle.
- **Fetch issue.** A fetch issues when all hold: no load/store, no `restart_i`, and count + inflight − pop < DEPTH, where pop = `dequeue_i` & `instruction_valid_o`.
  - Issue reads mem[PC], records (PC, inflight = 1), and sets PC = PC + 1.
  - PC wraps from 2^ADDR_W−1 to 0.
- **Fill.** Read data plus the recorded address are written to the queue tail in the cycle after issue.
  - The issue rule guarantees there is always room; overflow is impossible.
- **Dequeue.** `instruction_*` outputs show the head entry. A pop advances the head.
  - A simultaneous fill and pop keeps count unchanged.
- **Restart.** At the edge where `restart_i` = 1:
  - Queue emptied, in-flight read discarded, PC = `restart_addr_i`.
  - `dequeue_i` in that cycle is ignored.
  - `restart_i` overrides fetch issue only; a load/store in the same cycle still executes.
- **Load.** Reads mem[`load_store_addr_i`]. Result appears on `load_data_o` with `load_data_valid_o` = 1 for exactly the next cycle.
  - `load_data_o` holds its value otherwise.
- **Store.** Writes mem[addr] at the edge; no response.
  - A load or fetch issued in a later cycle sees the new data.

## Timing
- Restart at edge E: fetch issues at E+1, `instruction_valid_o` = 1 after E+2 with `instruction_addr_o` = `restart_addr_i`.
- Steady state: one instruction per cycle when `dequeue_i` is held and no load/store occurs. Each load/store inserts a one-cycle bubble.
- Load: request at edge L, data and valid during cycle L+1.
- Empty queue with `dequeue_i` = 1: no effect.
- Full queue: issue stalls until a pop.
- `rst` mid-operation: immediate return to the reset state, including any in-flight read.

## Configuration
- `FETCH_STORE_SNOOP_EN`
  - **Defined:** a store whose address matches any queued entry, or the in-flight read, replaces that entry's data with `store_data_i`. The in-flight read is substituted when it fills. Decode never sees stale self-modified code.
  - **Undefined:** queued and in-flight instructions keep their pre-store data; software must issue `restart_i` after modifying code.

## Test plan
- **Reset, then prefetch.** Reset, memory preloaded with mem[i] = i, no dequeue → after 2 cycles addr 0 valid with data 0; queue fills to 4 entries; addresses 0..3; issue then stalls.
- **Restart mid-stream.** Restart to 3 while entries 0..3 are queued → next edge valid = 0; 2 cycles later head addr 3, data 3; old entries never appear.
- **Store then restart.** Store 17'h10005 to addr 2, restart to 2 → head data 17'h10005, addr 2.
- **Load/fetch contention.** Load addr 7 while dequeuing continuously → `load_data_valid_o` pulses one cycle with mem[7]; exactly one fetch bubble; instruction order unbroken.
- **PC wrap.** ADDR_W = 4, restart to 14, dequeue held → addresses 14, 15, 0, 1 in consecutive cycles.
- **Snoop.** With `FETCH_STORE_SNOOP_EN`, store 17'h1FFFF to a queued address → that entry dequeues as 17'h1FFFF. Without the macro → old data.
